shift_mem_scheduler: RTL and testbench

Round-robin scheduler that shares one `shift_reg_mem` (32 × int8 parallel-load, serial-drain buffer) among `NUM_REQ` requesters. It grants one requester at a time and loads that requester's 32-byte vector with a one-cycle `write_enable`. It then tracks the 32-cycle drain and tags every element leaving the memory with its owner and index. Successive loads are issued back-to-back with no bubble.

---
 rtl/shift_mem_scheduler.sv | 146 ++++++++++++++
 tb/tb_shift_mem_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_mem_scheduler.sv
// Round-robin scheduler sharing one parallel-load / serial-drain shift memory.
// Loads the granted requester's vector, then tags every drained element with owner and index.
module shift_mem_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int DEPTH   = 32,
    parameter  int DATA_W  = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int OW      = $clog2(NUM_REQ)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    flush,
    input  logic [NUM_REQ-1:0]                      req_valid,
    input  logic [NUM_REQ-1:0][DEPTH-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]                      req_ready,
    output logic [DEPTH-1:0][DATA_W-1:0]            mem_write_data,
    output logic                                    mem_write_enable,
    input  logic [DATA_W-1:0]                       mem_read_data,
    input  logic [AW-1:0]                           mem_addr,
    output logic                                    out_valid,
    output logic [DATA_W-1:0]                       out_data,
    output logic [AW-1:0]                           out_index,
    output logic [OW-1:0]                           out_owner,
    output logic                                    out_last,
    output logic                                    busy,
    output logic                                    addr_err
);

    typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [AW-1:0]                   r_cnt;
    logic [OW-1:0]                   r_owner;
    logic [OW-1:0]                   r_rr_ptr;
    logic                            r_addr_err;
    logic [DEPTH-1:0][DATA_W-1:0]    r_wdata_hold;

    logic                            w_drain;
    logic                            w_cnt_last;
    logic                            w_eligible;
    logic                            w_found;
    logic [OW-1:0]                   w_win;
    logic                            w_transfer;

    assign w_drain    = (r_state == S_DRAIN);
    assign w_cnt_last = (r_cnt == AW'(DEPTH - 1));

    // Grants only while out of reset, not flushing, and idle or in the overlap slot.
    assign w_eligible = reset && !flush && (!w_drain || w_cnt_last);

    always_comb begin : arb
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = OW'(idx);
            end
        end
    end

    assign w_transfer = w_eligible && w_found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_transfer && (w_win == OW'(gi));
        end
    endgenerate

    assign mem_write_enable = w_transfer;
    assign mem_write_data   = w_transfer ? req_data[w_win] : r_wdata_hold;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_transfer) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (flush)           w_state_next = S_IDLE;
                else if (w_cnt_last) w_state_next = w_transfer ? S_DRAIN : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        out_valid = w_drain;
        busy      = w_drain;
        out_index = w_drain ? r_cnt : '0;
        out_owner = w_drain ? r_owner : '0;
        out_last  = w_drain && w_cnt_last;
        out_data  = w_drain ? mem_read_data : '0;
        addr_err  = r_addr_err;
    end

    // Counter only advances mid-drain; every other path reloads it to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_owner  <= '0;
            r_rr_ptr <= OW'(NUM_REQ - 1);
        end else if (w_transfer) begin
            r_cnt    <= '0;
            r_owner  <= w_win;
            r_rr_ptr <= w_win;
        end else if (w_drain && !flush && !w_cnt_last) begin
            r_cnt    <= r_cnt + 1'b1;
        end else begin
            r_cnt    <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdata_hold <= '0;
        end else if (w_transfer) begin
            r_wdata_hold <= req_data[w_win];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_err <= 1'b0;
        end else if (w_drain && (mem_addr != r_cnt)) begin
            r_addr_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_mem_scheduler.sv
// Directed bench for shift_mem_scheduler with a behavioural shift memory alongside.
module tb_shift_mem_scheduler;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  flush = 1'b0;
    logic [3:0]            req_valid = '0;
    logic [3:0][31:0][7:0] req_data;
    logic [3:0]            req_ready;
    logic [31:0][7:0]      mem_write_data;
    logic                  mem_write_enable;
    logic [7:0]            mem_read_data;
    logic [4:0]            mem_addr;
    logic                  out_valid;
    logic [7:0]            out_data;
    logic [4:0]            out_index;
    logic [1:0]            out_owner;
    logic                  out_last;
    logic                  busy;
    logic                  addr_err;

    logic [31:0][7:0]      m_mem = '0;
    logic [4:0]            m_addr = '0;
    logic [4:0]            addr_off = '0;

    int checks = 0;
    int errors = 0;

    shift_mem_scheduler #(.NUM_REQ(4), .DEPTH(32), .DATA_W(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data),
        .mem_addr         (mem_addr),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .out_index        (out_index),
        .out_owner        (out_owner),
        .out_last         (out_last),
        .busy             (busy),
        .addr_err         (addr_err)
    );

    always #5 clk = ~clk;

    // Shift memory model: parallel load restarts the address, otherwise it drains one per cycle.
    always @(posedge clk) begin
        if (mem_write_enable) begin
            m_mem  <= mem_write_data;
            m_addr <= '0;
        end else begin
            m_addr <= m_addr + 5'd1;
        end
    end
    assign mem_read_data = m_mem[m_addr];
    assign mem_addr      = m_addr + addr_off;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 32; i++)
                req_data[r][i] = 8'h00;

        // Reset state, with requests present to prove grants are suppressed
        req_valid = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_we", 64'(mem_write_enable), 64'h0);
        chk("rst_wdata_nz", 64'(mem_write_data != '0), 64'h0);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_err", 64'(addr_err), 64'h0);
        chk("rst_index", 64'(out_index), 64'h0);
        chk("rst_owner", 64'(out_owner), 64'h0);
        chk("rst_last", 64'(out_last), 64'h0);

        // Single load from requester 2
        req_valid = 4'b0000;
        for (int i = 0; i < 32; i++) req_data[2][i] = 8'(i + 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("s_ready", 64'(req_ready), 64'h4);
        chk("s_we", 64'(mem_write_enable), 64'h1);
        chk("s_wdata0", 64'(mem_write_data[0]), 64'h01);
        chk("s_wdata31", 64'(mem_write_data[31]), 64'h20);
        $display("load owner=2 (single)");
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("s_valid", 64'(out_valid), 64'h1);
            chk("s_index", 64'(out_index), 64'(i));
            chk("s_data", 64'(out_data), 64'(i + 1));
            chk("s_owner", 64'(out_owner), 64'h2);
            chk("s_last", 64'(out_last), 64'(i == 31));
            chk("s_we_drain", 64'(mem_write_enable), 64'h0);
            tick();
        end
        #1;
        chk("s_end_valid", 64'(out_valid), 64'h0);
        chk("s_end_busy", 64'(busy), 64'h0);
        chk("s_hold_wdata", 64'(mem_write_data[0]), 64'h01);

        // Round-robin after reset: expect 0,1,2,3,0 with no gaps
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 32; i++)
                req_data[r][i] = 8'(r * 64 + i);
        req_valid = 4'b1111;
        #1;
        chk("rr_first_ready", 64'(req_ready), 64'h1);
        chk("rr_first_we", 64'(mem_write_enable), 64'h1);
        for (int k = 0; k < 5; k++) begin
            $display("load owner=%0d (round-robin %0d)", k % 4, k);
            for (int i = 0; i < 32; i++) begin
                tick();
                if (k == 4 && i == 0) req_valid = 4'b0000;
                #1;
                chk("rr_valid", 64'(out_valid), 64'h1);
                chk("rr_owner", 64'(out_owner), 64'(k % 4));
                chk("rr_index", 64'(out_index), 64'(i));
                chk("rr_data", 64'(out_data), 64'((k % 4) * 64 + i));
                if (i == 31) begin
                    chk("rr_overlap_we", 64'(mem_write_enable), 64'(k < 4));
                    chk("rr_overlap_ready", 64'(req_ready),
                        (k < 4) ? 64'(1 << ((k + 1) % 4)) : 64'h0);
                end else if (i == 15) begin
                    chk("rr_mid_ready", 64'(req_ready), 64'h0);
                end
            end
        end
        tick();
        chk("rr_end_valid", 64'(out_valid), 64'h0);
        chk("rr_end_busy", 64'(busy), 64'h0);

        // Flush at index 10; rr_ptr is 0 so requester 1 wins over 3
        req_valid = 4'b1010;
        #1;
        chk("f_ready", 64'(req_ready), 64'h2);
        $display("load owner=1 (flush)");
        tick();
        req_valid = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("f_index", 64'(out_index), 64'(i));
            tick();
        end
        flush = 1'b1;
        #1;
        chk("f_at_index", 64'(out_index), 64'd10);
        chk("f_at_owner", 64'(out_owner), 64'h1);
        tick();
        flush = 1'b0;
        #1;
        chk("f_valid_drop", 64'(out_valid), 64'h0);
        chk("f_busy_drop", 64'(busy), 64'h0);
        req_valid = 4'b1111;
        #1;
        chk("f_next_ready", 64'(req_ready), 64'h4);
        chk("f_next_we", 64'(mem_write_enable), 64'h1);
        $display("load owner=2 (after flush)");

        // Flush in the overlap slot with requests pending
        for (int i = 0; i < 31; i++) begin
            tick();
            if (i == 5) begin
                chk("fo_mid_ready", 64'(req_ready), 64'h0);
                chk("fo_mid_owner", 64'(out_owner), 64'h2);
            end
        end
        tick();
        flush = 1'b1;
        #1;
        chk("fo_last", 64'(out_last), 64'h1);
        chk("fo_we", 64'(mem_write_enable), 64'h0);
        chk("fo_ready", 64'(req_ready), 64'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("fo_idle_valid", 64'(out_valid), 64'h0);
        chk("fo_idle_busy", 64'(busy), 64'h0);
        chk("fo_idle_ready", 64'(req_ready), 64'h8);
        chk("fo_idle_we", 64'(mem_write_enable), 64'h1);
        $display("load owner=3 (after overlap flush)");

        // Asynchronous reset at index 5
        tick();
        req_valid = 4'b0000;
        repeat (5) tick();
        chk("ar_pre_index", 64'(out_index), 64'd5);
        chk("ar_pre_owner", 64'(out_owner), 64'h3);
        reset = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'h0);
        chk("ar_busy", 64'(busy), 64'h0);
        chk("ar_owner", 64'(out_owner), 64'h0);
        chk("ar_index", 64'(out_index), 64'h0);
        chk("ar_data", 64'(out_data), 64'h0);
        chk("ar_wdata_nz", 64'(mem_write_data != '0), 64'h0);
        tick();
        reset = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("ar_first_ready", 64'(req_ready), 64'h1);
        $display("load owner=0 (after async reset)");

        // Address mismatch at index 7 sets a sticky error
        tick();
        req_valid = 4'b0000;
        repeat (7) tick();
        chk("ae_index", 64'(out_index), 64'd7);
        chk("ae_before", 64'(addr_err), 64'h0);
        addr_off = 5'd1;
        tick();
        addr_off = 5'd0;
        #1;
        chk("ae_set", 64'(addr_err), 64'h1);
        repeat (40) tick();
        chk("ae_sticky", 64'(addr_err), 64'h1);
        chk("ae_idle", 64'(out_valid), 64'h0);
        reset = 1'b0;
        #1;
        chk("ae_cleared", 64'(addr_err), 64'h0);
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
